// File: rtl/conv_window_mac.sv
// 3x3 sliding-window convolution over a raster pixel stream.
// Two row delay lines feed a 3x3 window; issued windows pass a fixed 4-stage MAC pipeline.
module conv_window_mac #(
    parameter int unsigned N     = 32,
    parameter int unsigned SHIFT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         pixel_in,
    input  logic               data_write,
    input  logic               enable,
    input  logic [71:0]        filter,
    output logic signed [19:0] result,
    output logic [7:0]         pixel_out,
    output logic               result_valid,
    output logic               frame_done
);

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned TAPS   = 9;
    localparam int unsigned PROD_W = 17;
    localparam int unsigned SUM_W  = 20;
    localparam int unsigned PTR_W  = $clog2(N);
    localparam int unsigned TOTAL  = (N - 2) * (N - 2);
    localparam int unsigned CNT_W  = $clog2(TOTAL + 1);

    // Row delay lines share one circular pointer; the slot read is the one about to be overwritten.
    logic [PIX_W-1:0] line1 [N];
    logic [PIX_W-1:0] line2 [N];
    logic [PTR_W-1:0] ptr;
    logic [PIX_W-1:0] dl1_out_c;
    logic [PIX_W-1:0] dl2_out_c;

    logic [PIX_W-1:0] win      [TAPS];
    logic [PIX_W-1:0] win_next_c [TAPS];

    // Stage A: captured window and coefficients
    logic                    a_valid;
    logic [PIX_W-1:0]        a_win  [TAPS];
    logic signed [PIX_W-1:0] a_coef [TAPS];

    // Stage B: registered products
    logic                     b_valid;
    logic signed [PROD_W-1:0] b_prod [TAPS];
    logic signed [PROD_W-1:0] prod_c [TAPS];

    // Stage C: registered sum
    logic                    c_valid;
    logic signed [SUM_W-1:0] c_sum;
    logic signed [SUM_W-1:0] sum_c;

    // Stage D helpers
    logic signed [SUM_W-1:0] shifted_c;
    logic [PIX_W-1:0]        sat_c;
    logic [CNT_W-1:0]        cnt;
    logic                    last_c;
    logic                    issue_c;

    assign dl1_out_c = line1[ptr];
    assign dl2_out_c = line2[ptr];
    assign issue_c   = data_write & enable;

    // Window after this cycle's push: shift left, new right column from delay lines and input
    always_comb begin
        for (int unsigned k = 0; k < TAPS; k++) begin
            win_next_c[k] = win[k];
        end
        for (int unsigned r = 0; r < 3; r++) begin
            win_next_c[3*r]     = win[3*r + 1];
            win_next_c[3*r + 1] = win[3*r + 2];
        end
        win_next_c[2] = dl2_out_c;
        win_next_c[5] = dl1_out_c;
        win_next_c[8] = pixel_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                line1[i] <= '0;
                line2[i] <= '0;
            end
            for (int unsigned k = 0; k < TAPS; k++) begin
                win[k] <= '0;
            end
            ptr <= '0;
        end else if (data_write) begin
            line1[ptr] <= pixel_in;
            line2[ptr] <= dl1_out_c;
            ptr        <= (ptr == PTR_W'(N - 1)) ? '0 : ptr + PTR_W'(1);
            for (int unsigned k = 0; k < TAPS; k++) begin
                win[k] <= win_next_c[k];
            end
        end
    end

    // Stage A capture; filter snapshot decouples the issue from later filter changes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_valid <= 1'b0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                a_win[k]  <= '0;
                a_coef[k] <= '0;
            end
        end else begin
            a_valid <= issue_c;
            if (issue_c) begin
                for (int unsigned k = 0; k < TAPS; k++) begin
                    a_win[k]  <= win_next_c[k];
                    a_coef[k] <= $signed(filter[(TAPS - 1 - k) * PIX_W +: PIX_W]);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < TAPS; k++) begin
            prod_c[k] = PROD_W'($signed({1'b0, a_win[k]})) * PROD_W'(a_coef[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_valid <= 1'b0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                b_prod[k] <= '0;
            end
        end else begin
            b_valid <= a_valid;
            if (a_valid) begin
                for (int unsigned k = 0; k < TAPS; k++) begin
                    b_prod[k] <= prod_c[k];
                end
            end
        end
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            sum_c = sum_c + SUM_W'(b_prod[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_valid <= 1'b0;
            c_sum   <= '0;
        end else begin
            c_valid <= b_valid;
            if (b_valid) begin
                c_sum <= sum_c;
            end
        end
    end

    // Scale and clamp to an unsigned 8-bit pixel
    always_comb begin
        shifted_c = c_sum >>> SHIFT;
        sat_c     = shifted_c[PIX_W-1:0];
        if (shifted_c < 0) begin
            sat_c = '0;
        end else if (shifted_c > SUM_W'(255)) begin
            sat_c = '1;
        end
    end

    assign last_c = (cnt == CNT_W'(TOTAL - 1));

    // Stage D: outputs hold between valid results; frame counter wraps on the last output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result       <= '0;
            pixel_out    <= '0;
            result_valid <= 1'b0;
            frame_done   <= 1'b0;
            cnt          <= '0;
        end else begin
            result_valid <= c_valid;
            frame_done   <= c_valid & last_c;
            if (c_valid) begin
                result    <= c_sum;
                pixel_out <= sat_c;
                cnt       <= last_c ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// Bench for conv_window_mac: two instances (SHIFT=0 and SHIFT=3) against a history-based window model.
module tb_conv_window_mac;

    localparam int NN    = 4;
    localparam int FRAME = (NN - 2) * (NN - 2);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        pixel_in = '0;
    logic              data_write = 1'b0;
    logic              enable = 1'b0;
    logic [71:0]       filter = '0;
    logic signed [19:0] result0, result3;
    logic [7:0]        pix0, pix3;
    logic              valid0, valid3, done0, done3;

    always #5 clk = ~clk;

    conv_window_mac #(.N(NN), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .data_write(data_write),
        .enable(enable), .filter(filter), .result(result0), .pixel_out(pix0),
        .result_valid(valid0), .frame_done(done0)
    );

    conv_window_mac #(.N(NN), .SHIFT(3)) dut_s (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .data_write(data_write),
        .enable(enable), .filter(filter), .result(result3), .pixel_out(pix3),
        .result_valid(valid3), .frame_done(done3)
    );

    typedef struct {
        int due;
        int res;
    } exp_t;

    exp_t expq[$];
    int   hist[$];
    int   cyc = 0;
    int   out_cnt = 0;
    int   last_res = 0;
    int   checks = 0;
    int   errors = 0;

    function automatic int sat(input int sum, input int s);
        int v;
        v = sum >>> s;
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int coef(input logic [71:0] f, input int k);
        logic signed [7:0] c;
        c = f[(8 - k) * 8 +: 8];
        return int'(c);
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Window tap (r,c) is the pixel pushed (2-r) rows and (2-c) columns before the newest one
    function automatic int model_sum(input logic [71:0] f);
        int m, idx, w, s;
        s = 0;
        m = hist.size() - 1;
        for (int k = 0; k < 9; k++) begin
            idx = m - (2 - k / 3) * NN - (2 - k % 3);
            w   = (idx >= 0) ? hist[idx] : 0;
            s  += w * coef(f, k);
        end
        return s;
    endfunction

    task automatic step(input logic dw, input logic en, input logic [7:0] pix, input logic [71:0] f);
        @(negedge clk);
        #1;
        data_write = dw;
        enable     = en;
        pixel_in   = pix;
        filter     = f;
        if (dw) begin
            hist.push_back(int'(pix));
            if (en) expq.push_back('{due: cyc + 4, res: model_sum(f)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, filter);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst        = 1'b0;
        data_write = 1'b0;
        enable     = 1'b0;
        hist.delete();
        expq.delete();
        out_cnt  = 0;
        last_res = 0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic frame(input logic [71:0] f, input logic gaps);
        for (int p = 0; p < NN * NN; p++) begin
            if (gaps && $urandom_range(0, 1) == 1) step(1'b0, 1'b1, 8'($urandom), f);
            step(1'b1, (p % NN >= 2) && (p / NN >= 2), 8'(p), f);
        end
    endtask

    // Output checker: compares every cycle against the expected-result queue
    always @(negedge clk) begin
        logic exp_valid;
        cyc++;
        if (!rst) begin
            chk("reset_result", result0, 0);
            chk("reset_pixel_out", pix0, 0);
            chk("reset_valid", valid0, 0);
            chk("reset_frame_done", done0, 0);
        end else begin
            exp_valid = (expq.size() > 0) && (expq[0].due == cyc);
            chk("result_valid", valid0, exp_valid);
            chk("result_valid_s3", valid3, exp_valid);
            if (exp_valid) begin
                last_res = expq[0].res;
                void'(expq.pop_front());
                out_cnt++;
                chk("result", result0, last_res);
                chk("result_s3", result3, last_res);
                chk("pixel_out", pix0, sat(last_res, 0));
                chk("pixel_out_s3", pix3, sat(last_res, 3));
                chk("frame_done", done0, out_cnt == FRAME);
                chk("frame_done_s3", done3, out_cnt == FRAME);
                if (out_cnt == FRAME) out_cnt = 0;
            end else begin
                chk("idle_frame_done", done0, 0);
                chk("hold_result", result0, last_res);
                chk("hold_pixel_out", pix0, sat(last_res, 0));
                chk("hold_pixel_out_s3", pix3, sat(last_res, 3));
            end
        end
    end

    initial begin
        logic [71:0] f_id, f_a, f_b;
        f_id = 72'h00_00_00_00_01_00_00_00_00;

        do_reset();

        // Identity filter over a ramp frame: interior centres 5,6,9,10
        frame(f_id, 1'b0);
        idle(6);

        // Same frame with write gaps and enable pulses on idle cycles
        frame(f_id, 1'b1);
        idle(6);

        // Extremes: saturated pixels against most negative / most positive coefficients
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'hff, {9{8'h80}});
        step(1'b1, 1'b1, 8'hff, {9{8'h80}});
        step(1'b1, 1'b1, 8'hff, {9{8'h7f}});
        idle(6);

        // Flat 10s with unit coefficients: sum 90, shifted by 3 gives 11
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'd10, {9{8'h01}});
        step(1'b1, 1'b1, 8'd10, {9{8'h01}});
        idle(6);

        // Filter change straight after an issue
        f_a = 72'({$urandom, $urandom, $urandom});
        f_b = 72'({$urandom, $urandom, $urandom});
        step(1'b1, 1'b1, 8'($urandom), f_a);
        step(1'b1, 1'b1, 8'($urandom), f_b);
        step(1'b1, 1'b0, 8'($urandom), f_b);
        step(1'b1, 1'b1, 8'($urandom), f_b);
        idle(6);

        // Random traffic
        f_a = 72'({$urandom, $urandom, $urandom});
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) f_a = 72'({$urandom, $urandom, $urandom});
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom), f_a);
        end
        idle(6);

        // Reset with three results in flight, then a fresh frame
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'($urandom), f_a);
        do_reset();
        idle(8);
        frame(72'({$urandom, $urandom, $urandom}), 1'b0);
        idle(6);

        chk("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
